// File: rtl/sysid_regbank.sv
// sysid_regbank: Avalon-MM system-ID slave with scratch, uptime, tick irq and info words.
// Read data is registered with fixed one-cycle latency; no waitrequest.
module sysid_regbank #(
   parameter logic [31:0] SYS_ID    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP = 32'd0,
   parameter logic [7:0]  VERSION   = 8'd2,
   parameter int          NUM_INFO  = 4,
   parameter logic [32*(NUM_INFO > 0 ? NUM_INFO : 1)-1:0] INFO_INIT = '0,
   parameter int          ADDR_W    = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              readdatavalid,
   output logic              irq
);
   logic [31:0] readdata_q, readdata_d, scratch_q, scratch_d, period_q, period_d;
   logic [31:0] hi_q, hi_d, cnt_q, cnt_d, info_w, rmux, be_mask;
   logic [63:0] uptime_q, uptime_d;
   logic        rdv_q, rdv_d, pend_q, pend_d, irq_en_q, irq_en_d, irq_q, irq_d;
   logic        rd, wr, wr_ctrl, wr_per, tick_last;

   always_comb begin
      info_w = '0;
      for (int k = 0; k < NUM_INFO; k++)
         if (address == ADDR_W'(8 + k)) info_w = INFO_INIT[32*k +: 32];
      case (address)
         ADDR_W'(0): rmux = SYS_ID;
         ADDR_W'(1): rmux = TIMESTAMP;
         ADDR_W'(2): rmux = {16'h0, VERSION, 8'(NUM_INFO)};
         ADDR_W'(3): rmux = scratch_q;
         ADDR_W'(4): rmux = uptime_q[31:0];
         ADDR_W'(5): rmux = hi_q;
         ADDR_W'(6): rmux = period_q;
         ADDR_W'(7): rmux = {30'h0, irq_en_q, pend_q};
         default:    rmux = info_w;
      endcase
   end

   always_comb begin
      rd         = chipselect & read;
      wr         = chipselect & write;
      be_mask    = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
      wr_ctrl    = wr && address == ADDR_W'(7) && byteenable[0];
      wr_per     = wr && address == ADDR_W'(6) && |byteenable;
      readdata_d = rd ? rmux : readdata_q;
      rdv_d      = rd;
      scratch_d  = wr && address == ADDR_W'(3) ? (scratch_q & ~be_mask) | (writedata & be_mask) : scratch_q;
      period_d   = wr_per ? (period_q & ~be_mask) | (writedata & be_mask) : period_q;
      uptime_d   = uptime_q + 64'd1;
      hi_d       = rd && address == ADDR_W'(4) ? uptime_q[63:32] : hi_q;
      tick_last  = period_q != 32'd0 && cnt_q == period_q - 32'd1;
      cnt_d      = wr_per || tick_last || period_q == 32'd0 ? 32'd0 : cnt_q + 32'd1;
      // a tick in the same cycle as a clear keeps pending set
      pend_d     = tick_last | (pend_q & ~(wr_ctrl & writedata[0]));
      irq_en_d   = wr_ctrl ? writedata[1] : irq_en_q;
      irq_d      = pend_d & irq_en_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
         rdv_q      <= 1'b0;
         scratch_q  <= '0;
         period_q   <= '0;
         uptime_q   <= '0;
         hi_q       <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         readdata_q <= readdata_d;
         rdv_q      <= rdv_d;
         scratch_q  <= scratch_d;
         period_q   <= period_d;
         uptime_q   <= uptime_d;
         hi_q       <= hi_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;
   assign irq           = irq_q;
endmodule

// File: doc/sysid_regbank.md
Name: sysid_regbank

Overview:
- Parameterised successor to the fixed two-word system-ID slave.
- Avalon-MM slave that returns a constant system ID and build timestamp, as before, plus:
  - a capability word
  - a scratch register
  - a 64-bit uptime counter with a coherent high-word snapshot
  - a programmable periodic tick interrupt
  - NUM_INFO constant build-info words
- Sits on the Nios II data bus. Software uses it for identification, timing and heartbeat.

Parameters:
- SYS_ID, 32'h0000_0000: value of the ID register.
- TIMESTAMP, 32'd0: build timestamp, in seconds since the Unix epoch.
- VERSION, 8'd2: block revision, reported in CAPS[15:8].
- NUM_INFO, 4: number of constant info words, range 0..16.
- INFO_INIT, {NUM_INFO*32{1'b0}}: packed info words. Word k is INFO_INIT[32k+31:32k].
- ADDR_W, 5: word-address width. Must satisfy 2^ADDR_W >= 8+NUM_INFO.

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, ADDR_W: word address.
- chipselect, input, 1: slave select.
- read, input, 1: read strobe. Qualified by chipselect.
- write, input, 1: write strobe. Qualified by chipselect.
- writedata, input, 32: write data.
- byteenable, input, 4: byte lanes for writes.
- readdata, output, 32: registered read data.
- readdatavalid, output, 1: high for one cycle when readdata is valid.
- irq, output, 1: tick interrupt. Level-sensitive, active-high.

Behaviour:
- Register map (word address, access, meaning):
  - 0, RO: SYS_ID.
  - 1, RO: TIMESTAMP.
  - 2, RO: CAPS = {16'h0, VERSION, NUM_INFO[7:0]}.
  - 3, RW: SCRATCH. Byteenable honoured.
  - 4, RO: UPTIME_LO. A read also copies uptime[63:32] into the HI shadow.
  - 5, RO: UPTIME_HI shadow.
  - 6, RW: TICK_PERIOD. Byteenable honoured. 0 = tick disabled.
  - 7, RW: CTRL/STATUS. Bit0 = pending (RO; write 1 to clear). Bit1 = irq_en (RW). Other bits read 0.
  - 8..8+NUM_INFO-1, RO: INFO words.
  - All other addresses read 0.
  - Writes to RO or unmapped addresses are ignored.
- Reset: while reset_n is low, all of the following are 0: readdata, readdatavalid, irq, SCRATCH, TICK_PERIOD, pending, irq_en, uptime, HI shadow, tick counter. Reset is asynchronous assert and acts mid-transaction; any read in flight is dropped (no readdatavalid).
- Read latency is fixed at 1. A cycle with chipselect&read at edge N gives readdata and readdatavalid=1 after edge N+1, for exactly one cycle. readdata holds its value between reads.
- No waitrequest. Back-to-back reads on every cycle are supported, with one readdatavalid per read.
- Writes take effect at the clock edge where chipselect&write is sampled. A read in the following cycle returns the new value.
- If read and write are asserted together, the write is performed and the read returns the pre-write value.
- Uptime: 64-bit, increments every clock after reset, wraps 2^64-1 -> 0.
  - A UPTIME_LO read sampled at edge N returns uptime[31:0] as it stood before edge N.
  - At the same edge the shadow captures uptime[63:32], so {HI, LO} is coherent.
  - The shadow changes only on a UPTIME_LO read.
- Tick counter: 32-bit.
  - When TICK_PERIOD=P≠0 it counts 0..P-1. On the cycle it equals P-1 it wraps to 0 and sets pending.
  - A write to TICK_PERIOD (any byte lane) clears the counter to 0.
  - P=0 holds the counter at 0 and never sets pending.
  - P=1 sets pending every cycle.
- Pending clear: writing CTRL with writedata[0]=1 and byteenable[0]=1 clears pending. If a tick event occurs in the same cycle, set wins and pending stays 1.
- irq = pending & irq_en, registered: it follows the pending/irq_en change by 0 extra cycles, i.e. it is driven from flops.

Test Plan:
- Reset, then read addresses 0, 1, 2 -> SYS_ID, TIMESTAMP, {16'h0, 8'd2, 8'd4}. Each readdatavalid comes exactly 1 cycle after its read.
- Write SCRATCH 32'hFFFF_FFFF with be=4'b1111, then 32'h1234_5678 with be=4'b0101 -> read returns 32'hFF34_FF78. Write to address 0 -> ID unchanged.
- Force uptime to 32'h0000_0000_FFFF_FFFF. Read LO -> 32'hFFFF_FFFF, then read HI -> 0 (not 1). Reading HI again after 10 cycles is still 0.
- TICK_PERIOD=4, irq_en=1 -> pending/irq rise every 4 cycles. W1C in the same cycle as a tick -> pending stays 1. W1C on another cycle -> irq low the next cycle.
- Back-to-back reads of addresses 8, 9, 10, 11, 12 (NUM_INFO=4) -> 4 INFO words then 0, with 5 consecutive readdatavalid pulses.
- Assert reset_n low mid-read with P=2 running -> readdatavalid=0, irq=0, and all registers at 0 immediately, without waiting for a clock.
